blake_state_bank: RTL and testbench

- Parametrised BLAKE compression state controller: one 16-word working state per lane.
- Loads initial state from chaining value, counter and constants, then sequences ROUNDS rounds through an external combinational round core.
- Applies the BLAKE finalization h' = h ^ v[i] ^ v[i+8] (salt = 0) and presents the result on a valid/ready output.
- Sits between the message/padding front-end and the digest output; supports BLAKE-512 (64-bit words) and BLAKE-256 (32-bit words) with N parallel lanes.

---
 rtl/blake_pkg.sv | 82 ++++++++
 rtl/blake_state_init.sv | 35 +++
 rtl/blake_state_bank.sv | 135 +++++++++++++
 tb/tb_blake_state_bank.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake_pkg.sv
// blake_pkg: BLAKE constants, IVs, controller state type and word-offset helpers
// shared by the BLAKE state bank and its init-vector builder.
package blake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } bank_state_t;

    localparam int WORDS_H = 8;
    localparam int WORDS_V = 16;

    // Constants c0..c7 (leading hex digits of pi); 32-bit values come back zero-extended.
    function automatic logic [63:0] blake_const(input int word_w, input int idx);
        logic [63:0] c;
        c = '0;
        if (word_w == 64) begin
            case (idx)
                0: c = 64'h243F6A8885A308D3;
                1: c = 64'h13198A2E03707344;
                2: c = 64'hA4093822299F31D0;
                3: c = 64'h082EFA98EC4E6C89;
                4: c = 64'h452821E638D01377;
                5: c = 64'hBE5466CF34E90C6C;
                6: c = 64'hC0AC29B7C97C50DD;
                7: c = 64'h3F84D5B5B5470917;
                default: c = '0;
            endcase
        end else begin
            case (idx)
                0: c = 64'h00000000243F6A88;
                1: c = 64'h0000000085A308D3;
                2: c = 64'h0000000013198A2E;
                3: c = 64'h0000000003707344;
                4: c = 64'h00000000A4093822;
                5: c = 64'h00000000299F31D0;
                6: c = 64'h00000000082EFA98;
                7: c = 64'h00000000EC4E6C89;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    function automatic logic [63:0] blake_iv(input int word_w, input int idx);
        logic [63:0] c;
        c = '0;
        if (word_w == 64) begin
            case (idx)
                0: c = 64'h6A09E667F3BCC908;
                1: c = 64'hBB67AE8584CAA73B;
                2: c = 64'h3C6EF372FE94F82B;
                3: c = 64'hA54FF53A5F1D36F1;
                4: c = 64'h510E527FADE682D1;
                5: c = 64'h9B05688C2B3E6C1F;
                6: c = 64'h1F83D9ABFB41BD6B;
                7: c = 64'h5BE0CD19137E2179;
                default: c = '0;
            endcase
        end else begin
            case (idx)
                0: c = 64'h000000006A09E667;
                1: c = 64'h00000000BB67AE85;
                2: c = 64'h000000003C6EF372;
                3: c = 64'h00000000A54FF53A;
                4: c = 64'h00000000510E527F;
                5: c = 64'h000000009B05688C;
                6: c = 64'h000000001F83D9AB;
                7: c = 64'h000000005BE0CD19;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    // Vectors store word 0 at the MSBs, so word idx of 'count' words starts here.
    function automatic int word_lsb(input int idx, input int count, input int word_w);
        return (count - 1 - idx) * word_w;
    endfunction

endpackage

// File: rtl/blake_state_init.sv
// blake_state_init: combinational BLAKE working-state builder for one lane,
// v = {h, c0..c3, counter-XORed c4..c7}, counter skipped when t_null is set.
module blake_state_init
    import blake_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic [8*WORD_W-1:0]  h,
    input  logic [2*WORD_W-1:0]  t,
    input  logic                 t_null,
    output logic [16*WORD_W-1:0] v_init
);

    logic [WORD_W-1:0] t0;
    logic [WORD_W-1:0] t1;

    assign t0 = t[2*WORD_W-1:WORD_W];
    assign t1 = t[WORD_W-1:0];

    always_comb begin
        v_init = '0;
        for (int i = 0; i < WORDS_H; i++) begin
            v_init[word_lsb(i, WORDS_V, WORD_W) +: WORD_W]     = h[word_lsb(i, WORDS_H, WORD_W) +: WORD_W];
            v_init[word_lsb(i + 8, WORDS_V, WORD_W) +: WORD_W] = WORD_W'(blake_const(WORD_W, i));
        end
        // A block without message bits leaves the counter out of the state entirely.
        if (!t_null) begin
            v_init[word_lsb(12, WORDS_V, WORD_W) +: WORD_W] = v_init[word_lsb(12, WORDS_V, WORD_W) +: WORD_W] ^ t0;
            v_init[word_lsb(13, WORDS_V, WORD_W) +: WORD_W] = v_init[word_lsb(13, WORDS_V, WORD_W) +: WORD_W] ^ t0;
            v_init[word_lsb(14, WORDS_V, WORD_W) +: WORD_W] = v_init[word_lsb(14, WORDS_V, WORD_W) +: WORD_W] ^ t1;
            v_init[word_lsb(15, WORDS_V, WORD_W) +: WORD_W] = v_init[word_lsb(15, WORDS_V, WORD_W) +: WORD_W] ^ t1;
        end
    end

endmodule

// File: rtl/blake_state_bank.sv
// blake_state_bank: multi-lane BLAKE compression state controller around an external round core.
// Optional BLAKE_STATE_CHAIN_EN adds chain_sel to reuse the last h_out as the next chaining value.
module blake_state_bank
    import blake_pkg::*;
#(
    parameter  int WORD_W = 64,
    parameter  int LANES  = 1,
    parameter  int ROUNDS = 16,
    localparam int RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [LANES*8*WORD_W-1:0]    h_in,
    input  logic [2*WORD_W-1:0]          t_in,
    input  logic                         t_null,
`ifdef BLAKE_STATE_CHAIN_EN
    input  logic                         chain_sel,
`endif
    output logic [RND_W-1:0]             round_idx,
    output logic [LANES*16*WORD_W-1:0]   v_cur,
    input  logic [LANES*16*WORD_W-1:0]   v_next,
    output logic [LANES*8*WORD_W-1:0]    h_out,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int HW = 8 * WORD_W;
    localparam int VW = 16 * WORD_W;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

    bank_state_t state;
    bank_state_t state_nxt;

    logic                accept;
    logic                last_round;
    logic                out_done;
    logic [LANES*HW-1:0] h_reg;
    logic [LANES*HW-1:0] h_sel;
    logic [LANES*HW-1:0] h_fin;
    logic [LANES*VW-1:0] v_init;

`ifdef BLAKE_STATE_CHAIN_EN
    assign h_sel = chain_sel ? h_out : h_in;
`else
    assign h_sel = h_in;
`endif

    // Finalization per lane: h ^ v[0..7] ^ v[8..15], i.e. the upper half of v against the lower half.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int HO = (LANES - 1 - l) * HW;
        localparam int VO = (LANES - 1 - l) * VW;

        blake_state_init #(
            .WORD_W (WORD_W)
        ) u_init (
            .h      (h_sel[HO +: HW]),
            .t      (t_in),
            .t_null (t_null),
            .v_init (v_init[VO +: VW])
        );

        assign h_fin[HO +: HW] = h_reg[HO +: HW] ^ v_next[VO + HW +: HW] ^ v_next[VO +: HW];
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        accept      = 1'b0;
        last_round  = 1'b0;
        out_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (round_idx == LAST_RND) begin
                    last_round = 1'b1;
                    state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid && out_ready) begin
                    out_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // v_cur is forced to zero outside ROUND so the round core sees a quiescent input.
    always_ff @(posedge clk) begin
        if (rstb) begin
            h_reg     <= '0;
            v_cur     <= '0;
            round_idx <= '0;
            h_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                h_reg     <= h_sel;
                v_cur     <= v_init;
                round_idx <= '0;
            end else if (state == ST_ROUND) begin
                if (last_round) begin
                    h_out     <= h_fin;
                    out_valid <= 1'b1;
                    v_cur     <= '0;
                    round_idx <= '0;
                end else begin
                    v_cur     <= v_next;
                    round_idx <= round_idx + 1'b1;
                end
            end
            if (out_done) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blake_state_bank.sv
// tb_blake_state_bank: checks a 64-bit single-lane bank and a 32-bit two-lane bank
// against an array-based BLAKE state model driven through a bench-owned round stub.
module tb_blake_state_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb;
    logic stub_mode;

    logic          start_valid_a, start_ready_a, t_null_a, out_valid_a, out_ready_a;
    logic [511:0]  h_in_a, h_out_a;
    logic [127:0]  t_in_a;
    logic [3:0]    round_idx_a;
    logic [1023:0] v_cur_a, v_next_a, first_v_a;

    logic          start_valid_b, start_ready_b, t_null_b, out_valid_b, out_ready_b;
    logic [511:0]  h_in_b, h_out_b;
    logic [63:0]   t_in_b;
    logic [3:0]    round_idx_b;
    logic [1023:0] v_cur_b, v_next_b;

`ifdef BLAKE_STATE_CHAIN_EN
    logic chain_sel_a, chain_sel_b;
`endif

    int total = 0;
    int bad   = 0;

    logic [63:0] c64 [8] = '{64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
                             64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917};
    logic [63:0] c32 [8] = '{64'h243F6A88, 64'h85A308D3, 64'h13198A2E, 64'h03707344,
                             64'hA4093822, 64'h299F31D0, 64'h082EFA98, 64'hEC4E6C89};
    logic [63:0] iv64 [8] = '{64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
                              64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};

    logic [63:0] m_h   [2][8];
    logic [63:0] m_v0  [2][16];
    logic [63:0] m_out [2][8];

    typedef struct {
        logic [63:0] t0;
        logic [63:0] t1;
        bit          tnull;
        logic [63:0] e12;
        logic [63:0] e13;
        logic [63:0] e14;
        logic [63:0] e15;
    } init_vec_t;

    init_vec_t tbl [4];

    blake_state_bank #(.WORD_W(64), .LANES(1), .ROUNDS(16)) dut_a (
        .clk         (clk),
        .rstb        (rstb),
        .start_valid (start_valid_a),
        .start_ready (start_ready_a),
        .h_in        (h_in_a),
        .t_in        (t_in_a),
        .t_null      (t_null_a),
`ifdef BLAKE_STATE_CHAIN_EN
        .chain_sel   (chain_sel_a),
`endif
        .round_idx   (round_idx_a),
        .v_cur       (v_cur_a),
        .v_next      (v_next_a),
        .h_out       (h_out_a),
        .out_valid   (out_valid_a),
        .out_ready   (out_ready_a)
    );

    blake_state_bank #(.WORD_W(32), .LANES(2), .ROUNDS(14)) dut_b (
        .clk         (clk),
        .rstb        (rstb),
        .start_valid (start_valid_b),
        .start_ready (start_ready_b),
        .h_in        (h_in_b),
        .t_in        (t_in_b),
        .t_null      (t_null_b),
`ifdef BLAKE_STATE_CHAIN_EN
        .chain_sel   (chain_sel_b),
`endif
        .round_idx   (round_idx_b),
        .v_cur       (v_cur_b),
        .v_next      (v_next_b),
        .h_out       (h_out_b),
        .out_valid   (out_valid_b),
        .out_ready   (out_ready_b)
    );

    // Stand-in round core: any round-dependent mixing works, identity when stub_mode is 0.
    function automatic logic [63:0] core_word(input logic [63:0] a, input logic [63:0] b, input int k, input int r);
        return (b ^ (a << 1)) + 64'(k) + 64'(3 * r);
    endfunction

    always_comb begin
        v_next_a = v_cur_a;
        if (stub_mode) begin
            for (int k = 0; k < 16; k++) begin
                v_next_a[(15 - k) * 64 +: 64] = core_word(v_cur_a[(15 - k) * 64 +: 64],
                                                          v_cur_a[(15 - ((k + 1) % 16)) * 64 +: 64],
                                                          k, int'(round_idx_a));
            end
        end
    end

    always_comb begin
        v_next_b = v_cur_b;
        if (stub_mode) begin
            for (int l = 0; l < 2; l++) begin
                for (int k = 0; k < 16; k++) begin
                    v_next_b[(1 - l) * 512 + (15 - k) * 32 +: 32] =
                        32'(core_word({32'h0, v_cur_b[(1 - l) * 512 + (15 - k) * 32 +: 32]},
                                      {32'h0, v_cur_b[(1 - l) * 512 + (15 - ((k + 1) % 16)) * 32 +: 32]},
                                      k, int'(round_idx_b)));
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whole compression at word level: build v, run the stub rounds, fold into h.
    task automatic model_run(input int w, input int lanes, input int rounds,
                             input logic [63:0] t0, input logic [63:0] t1, input bit tnull);
        logic [63:0] mask;
        logic [63:0] v  [16];
        logic [63:0] nv [16];
        mask = (w == 64) ? {64{1'b1}} : 64'h00000000FFFFFFFF;
        for (int l = 0; l < lanes; l++) begin
            for (int i = 0; i < 8; i++) begin
                v[i]     = m_h[l][i] & mask;
                v[i + 8] = (w == 64) ? c64[i] : c32[i];
            end
            if (!tnull) begin
                v[12] = v[12] ^ (t0 & mask);
                v[13] = v[13] ^ (t0 & mask);
                v[14] = v[14] ^ (t1 & mask);
                v[15] = v[15] ^ (t1 & mask);
            end
            for (int i = 0; i < 16; i++) m_v0[l][i] = v[i];
            for (int r = 0; r < rounds; r++) begin
                if (stub_mode) begin
                    for (int k = 0; k < 16; k++) nv[k] = core_word(v[k], v[(k + 1) % 16], k, r) & mask;
                    v = nv;
                end
            end
            for (int i = 0; i < 8; i++) m_out[l][i] = (m_h[l][i] & mask) ^ v[i] ^ v[i + 8];
        end
    endtask

    task automatic apply_stimulus_a(input string tag, input logic [63:0] t0, input logic [63:0] t1,
                                    input bit tnull, input bit chain, input int hold);
        int edges;
        model_run(64, 1, 16, t0, t1, tnull);
        for (int i = 0; i < 8; i++) h_in_a[(7 - i) * 64 +: 64] = chain ? {$urandom, $urandom} : m_h[0][i];
`ifdef BLAKE_STATE_CHAIN_EN
        chain_sel_a = chain;
`endif
        t_in_a   = {t0, t1};
        t_null_a = tnull;
        check_output({tag, " idle_ready"}, 64'(start_ready_a), 64'd1);
        start_valid_a = 1'b1;
        @(posedge clk); #1;
        // Keep start_valid high and scramble inputs: nothing may be re-latched mid-compression.
        for (int i = 0; i < 16; i++) h_in_a[i * 32 +: 32] = $urandom;
        t_in_a    = {$urandom, $urandom, $urandom, $urandom};
        t_null_a  = ~tnull;
        first_v_a = v_cur_a;
        check_output({tag, " busy_ready"}, 64'(start_ready_a), 64'd0);
        check_output({tag, " round0"}, 64'(round_idx_a), 64'd0);
        for (int i = 0; i < 16; i++)
            if (i == 0 || i == 8 || i >= 12)
                check_output($sformatf("%s v_init%0d", tag, i), v_cur_a[(15 - i) * 64 +: 64], m_v0[0][i]);
        edges = 0;
        while (!out_valid_a && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        start_valid_a = 1'b0;
        check_output({tag, " latency"}, 64'(edges), 64'd16);
        check_output({tag, " v_quiet"}, 64'(v_cur_a != '0), 64'd0);
        for (int i = 0; i < 8; i++)
            check_output($sformatf("%s h_out%0d", tag, i), h_out_a[(7 - i) * 64 +: 64], m_out[0][i]);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check_output({tag, " hold_valid"}, 64'(out_valid_a), 64'd1);
            check_output({tag, " hold_h0"}, h_out_a[7 * 64 +: 64], m_out[0][0]);
        end
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        check_output({tag, " drop_valid"}, 64'(out_valid_a), 64'd0);
        check_output({tag, " back_idle"}, 64'(start_ready_a), 64'd1);
    endtask

    task automatic apply_stimulus_b(input string tag, input logic [31:0] t0, input logic [31:0] t1, input bit tnull);
        int edges;
        model_run(32, 2, 14, {32'h0, t0}, {32'h0, t1}, tnull);
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 8; i++) h_in_b[(1 - l) * 256 + (7 - i) * 32 +: 32] = m_h[l][i][31:0];
        t_in_b   = {t0, t1};
        t_null_b = tnull;
        check_output({tag, " idle_ready"}, 64'(start_ready_b), 64'd1);
        start_valid_b = 1'b1;
        @(posedge clk); #1;
        start_valid_b = 1'b0;
        check_output({tag, " l1_v12"}, {32'h0, v_cur_b[3 * 32 +: 32]}, m_v0[1][12]);
        edges = 0;
        while (!out_valid_b && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check_output({tag, " latency"}, 64'(edges), 64'd14);
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 8; i++)
                check_output($sformatf("%s l%0d h_out%0d", tag, l, i),
                             {32'h0, h_out_b[(1 - l) * 256 + (7 - i) * 32 +: 32]}, m_out[l][i]);
        out_ready_b = 1'b1;
        @(posedge clk); #1;
        out_ready_b = 1'b0;
        check_output({tag, " drop_valid"}, 64'(out_valid_b), 64'd0);
    endtask

    initial begin
        int edges;
`ifdef BLAKE_STATE_CHAIN_EN
        logic [63:0] first_out [8];
        chain_sel_a = 1'b0;
        chain_sel_b = 1'b0;
`endif
        tbl[0] = '{64'd640, 64'd0, 1'b0, 64'h452821E638D011F7, 64'hBE5466CF34E90EEC, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917};
        tbl[1] = '{64'd640, 64'd0, 1'b1, 64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917};
        tbl[2] = '{64'd0, 64'h200, 1'b0, 64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C52DD, 64'h3F84D5B5B5470B17};
        tbl[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h452821E638D01377, 64'hBE5466CF34E90C6C,
                   64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917};

        rstb = 1'b1;
        stub_mode = 1'b0;
        start_valid_a = 1'b0; out_ready_a = 1'b0; t_null_a = 1'b0; h_in_a = '0; t_in_a = '0;
        start_valid_b = 1'b0; out_ready_b = 1'b0; t_null_b = 1'b0; h_in_b = '0; t_in_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst a_valid", 64'(out_valid_a), 64'd0);
        check_output("rst a_ready", 64'(start_ready_a), 64'd1);
        check_output("rst a_v", 64'(v_cur_a != '0), 64'd0);
        check_output("rst a_h", 64'(h_out_a != '0), 64'd0);
        check_output("rst a_round", 64'(round_idx_a), 64'd0);
        check_output("rst b_valid", 64'(out_valid_b), 64'd0);
        check_output("rst b_v", 64'(v_cur_b != '0), 64'd0);
        rstb = 1'b0;

        // Identity round core: h_out collapses to v[8..15] of the init vector.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++) m_h[0][i] = iv64[i];
            apply_stimulus_a($sformatf("vec%0d", n), tbl[n].t0, tbl[n].t1, tbl[n].tnull, 1'b0, (n == 0) ? 5 : 0);
            check_output($sformatf("vec%0d w12", n), first_v_a[3 * 64 +: 64], tbl[n].e12);
            check_output($sformatf("vec%0d w13", n), first_v_a[2 * 64 +: 64], tbl[n].e13);
            check_output($sformatf("vec%0d w14", n), first_v_a[1 * 64 +: 64], tbl[n].e14);
            check_output($sformatf("vec%0d w15", n), first_v_a[0 * 64 +: 64], tbl[n].e15);
            check_output($sformatf("vec%0d out0", n), h_out_a[7 * 64 +: 64], 64'h243F6A8885A308D3);
            check_output($sformatf("vec%0d out4", n), h_out_a[3 * 64 +: 64], tbl[n].e12);
        end

        stub_mode = 1'b1;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++) m_h[0][i] = {$urandom, $urandom};
            apply_stimulus_a($sformatf("rnd_a%0d", n), {$urandom, $urandom}, {$urandom, $urandom},
                             ($urandom_range(0, 3) == 0), 1'b0, 0);
        end

        for (int n = 0; n < 3; n++) begin
            for (int l = 0; l < 2; l++)
                for (int i = 0; i < 8; i++) m_h[l][i] = {32'h0, $urandom};
            apply_stimulus_b($sformatf("rnd_b%0d", n), $urandom, $urandom, (n == 2));
        end

        // Reset in the middle of round 7 must abort without producing output.
        for (int i = 0; i < 8; i++) h_in_a[(7 - i) * 64 +: 64] = {$urandom, $urandom};
        t_in_a = {$urandom, $urandom, $urandom, $urandom};
        start_valid_a = 1'b1;
        @(posedge clk); #1;
        start_valid_a = 1'b0;
        edges = 0;
        while (round_idx_a != 4'd7 && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        check_output("abort reach7", 64'(round_idx_a), 64'd7);
        rstb = 1'b1;
        @(posedge clk); #1;
        rstb = 1'b0;
        check_output("abort valid", 64'(out_valid_a), 64'd0);
        check_output("abort v", 64'(v_cur_a != '0), 64'd0);
        check_output("abort ready", 64'(start_ready_a), 64'd1);
        check_output("abort round", 64'(round_idx_a), 64'd0);
        check_output("abort h", 64'(h_out_a != '0), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check_output("abort silent", 64'(out_valid_a), 64'd0);
        for (int i = 0; i < 8; i++) m_h[0][i] = {$urandom, $urandom};
        apply_stimulus_a("after_abort", {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 2);

`ifdef BLAKE_STATE_CHAIN_EN
        for (int i = 0; i < 8; i++) m_h[0][i] = {$urandom, $urandom};
        apply_stimulus_a("chain_blk1", 64'd1024, 64'd0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) first_out[i] = m_out[0][i];
        for (int i = 0; i < 8; i++) m_h[0][i] = first_out[i];
        apply_stimulus_a("chain_blk2", 64'd2048, 64'd0, 1'b0, 1'b1, 0);
        chain_sel_a = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
